// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle evaluation of the logic/arithmetic opcodes (0-7) and their flags.
// Illegal opcodes yield result 0 with err set; iterative opcodes yield 0 here.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] res,
  output flags_t           flags
);

  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           msb_x;
  logic           msb_y;

  // The top bit of each widened sum is the carry-out; for x+~y+1 it is no-borrow.
  assign sum   = {1'b0, x} + {1'b0, y};
  assign diff  = {1'b0, x} + {1'b0, ~y} + ONE;
  assign msb_x = x[WIDTH-1];
  assign msb_y = y[WIDTH-1];

  // Opcode decode with carry/overflow only on ADD and SUB.
  always_comb begin
    res            = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    flags.err      = 1'b0;
    case (op)
      OP_ADD: begin
        res            = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (msb_x == msb_y) && (sum[WIDTH-1] != msb_x);
      end
      OP_SUB: begin
        res            = diff[WIDTH-1:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (msb_x != msb_y) && (diff[WIDTH-1] != msb_x);
      end
      OP_NOT: res = ~x;
      OP_AND: res = x & y;
      OP_OR:  res = x | y;
      OP_XOR: res = x ^ y;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_EQ:  res = {{(WIDTH-1){1'b0}}, (x == y)};
      default: flags.err = (op >= OP_ILLEGAL_MIN);
    endcase
    flags.zero     = (res == '0);
    flags.negative = res[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU. Simple ops finish in one cycle; shifts move one bit per cycle
// and MUL does one shift-add step per multiplier bit. Result and flags are held
// in registers while DONE waits for the consumer.
// Handshake: a transfer happens on an edge where valid && ready; the input side
// is ready only in IDLE, and the output side presents valid only in DONE.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             err,
  output logic             busy
);

  localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);
  localparam logic [SHW:0] CNT_FULL = (SHW + 1)'(WIDTH);

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  logic [WIDTH-1:0] comb_res;
  flags_t           comb_flags;
  logic [WIDTH-1:0] acc_nxt;
  logic [SHW:0]     amt;
  logic             is_shift;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (op),
    .x     (x),
    .y     (y),
    .res   (comb_res),
    .flags (comb_flags)
  );

  assign amt      = {1'b0, y[SHW-1:0]};
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // One iteration step: a single-bit shift, or one multiplier-bit shift-add.
  always_comb begin
    acc_nxt = acc;
    case (op_q)
      OP_SLL:  acc_nxt = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_nxt = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_nxt = mplier[0] ? (acc + mcand) : acc;
    endcase
  end

  // FSM, iteration registers and the held output bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (is_shift && (amt != '0)) begin
              acc   <= x;
              cnt   <= amt;
              state <= S_BUSY;
            end else if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= x;
              mplier <= y;
              cnt    <= CNT_FULL;
              state  <= S_BUSY;
            end else if (is_shift) begin
              // Zero shift amount passes x through without iterating.
              result_q <= x;
              flags_q  <= '{carry: 1'b0, overflow: 1'b0, zero: (x == '0),
                            negative: x[WIDTH-1], err: 1'b0};
              state    <= S_DONE;
            end else begin
              result_q <= comb_res;
              flags_q  <= comb_flags;
              state    <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result_q <= acc_nxt;
            flags_q  <= '{carry: 1'b0, overflow: 1'b0, zero: (acc_nxt == '0),
                          negative: acc_nxt[WIDTH-1], err: 1'b0};
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE) && rst_n;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed plan steps followed by random ops,
// each compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         in_ready, out_valid, carry, overflow, zero, negative, err, busy;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .err       (err),
    .busy      (busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic void model(input int o, input int a, input int b,
                                output int res, output int c, output int v,
                                output int e, output int lat);
    int sa, sb, s, amt;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    amt = b % W;
    res = 0; c = 0; v = 0; e = 0; lat = 1;
    case (o)
      0: begin s = a + b; res = s & 255; c = (s > 255); s = sa + sb; v = (s > 127 || s < -128); end
      1: begin res = (a - b) & 255; c = (a >= b); s = sa - sb; v = (s > 127 || s < -128); end
      2: res = (~a) & 255;
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = (sa < sb) ? 1 : 0;
      7: res = (a == b) ? 1 : 0;
      8: begin res = (a << amt) & 255; lat = amt + 1; end
      9: begin res = a >> amt; lat = amt + 1; end
      10: begin res = (sa >>> amt) & 255; lat = amt + 1; end
      11: begin res = (a * b) & 255; lat = W + 1; end
      default: e = 1;
    endcase
  endfunction

  // Drive one op, measure latency, check output, optionally stall the consumer.
  task automatic run_op(input int o, input int a, input int b, input int hold,
                        output logic [W-1:0] got);
    int er, ec, ev, ee, el, lat;
    logic [W-1:0] held;
    model(o, a, b, er, ec, ev, ee, el);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    op = o[3:0]; x = a[W-1:0]; y = b[W-1:0]; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) check("busy_during", busy, 1);
    end while (!out_valid && lat < 50);
    check($sformatf("latency op%0d", o), lat, el);
    check($sformatf("result op%0d", o), result, er);
    check($sformatf("flags op%0d", o), {carry, overflow, zero, negative, err},
          {ec[0], ev[0], (er == 0), er[7], ee[0]});
    held = result;
    got  = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op = 4'($urandom_range(0, 15));
      x  = 8'($urandom);
      y  = 8'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, held);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin : main
    logic [W-1:0] g;
    bit seen;
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, overflow, zero, negative, err}, 0);
    rst_n = 1'b1;

    // Directed plan
    run_op(0, 'h7F, 'h01, 0, g); check("plan_add", g, 'h80);
    run_op(1, 'h80, 'h01, 0, g); check("plan_sub_ov", g, 'h7F);
    run_op(1, 'h05, 'h07, 0, g); check("plan_sub_neg", g, 'hFE);
    run_op(7, 'h3C, 'h3C, 0, g); check("plan_eq", g, 'h01);
    run_op(6, 'hFF, 'h01, 0, g); check("plan_slt", g, 'h01);
    run_op(8, 'h81, 'h03, 0, g); check("plan_sll", g, 'h08);
    run_op(10, 'h90, 'h02, 0, g); check("plan_sra", g, 'hE4);
    run_op(9, 'h90, 'h08, 0, g); check("plan_srl0", g, 'h90);
    run_op(11, 13, 11, 0, g); check("plan_mul", g, 'h8F);
    run_op(11, 'h10, 'h10, 0, g); check("plan_mul_zero", g, 'h00);
    run_op(0, 'h21, 'h42, 5, g); check("plan_backpressure", g, 'h63);
    run_op(13, 'h55, 'h66, 0, g); check("plan_illegal", g, 'h00);

    // Reset during the 4th busy cycle of a MUL
    @(negedge clk);
    op = 4'd11; x = 8'd13; y = 8'd11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", {carry, overflow, zero, negative, err}, 0);
    check("midrst_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_late_valid", seen, 0);

    // Random ops
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 2), g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Adds signed/unsigned flags and iterative multi-cycle ops: shift by variable amount, and shift-add multiply.
- Sits between the operand-fetch stage and the writeback/display logic of the lab datapath.
- Uses valid/ready on both sides and holds its result under backpressure.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- op  in  4  opcode.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B; for shifts, y[SHW-1:0] is the amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result.
- carry  out  1  carry/no-borrow flag.
- overflow  out  1  signed overflow flag.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- err  out  1  illegal opcode.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: rst_n sampled low at an edge forces state IDLE, clears internal counters, and sets result and every flag to 0. This holds mid-operation; an in-flight op is dropped silently. in_ready is 0 while rst_n is low.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) && rst_n. out_valid = (state==DONE). busy = (state!=IDLE).
- Accept: in_valid && in_ready at the cycle-C edge latches op, x and y.
- Opcodes:
  - 0 ADD, 1 SUB, 2 NOT (~x), 3 AND, 4 OR, 5 XOR, 6 SLT (signed x<y, result 1 or 0, zero-extended), 7 EQ (x==y, zero-extended).
  - 8 SLL, 9 SRL, 10 SRA.
  - 11 MUL (low WIDTH bits of unsigned x*y).
  - 12-15 illegal.
- Latency:
  - Ops 0-7, illegal opcodes, and shifts with amount 0: go straight to DONE; out_valid in cycle C+1.
  - Shifts with amount n>0: BUSY for cycles C+1..C+n, one bit per cycle; out_valid in C+n+1.
  - MUL: BUSY for exactly WIDTH cycles (one multiplier bit per cycle, LSB first); out_valid in C+WIDTH+1. Latency is independent of operand values.
- Flags:
  - ADD: carry = carry-out of the WIDTH-bit add. overflow = (x[msb]==y[msb]) && (res[msb]!=x[msb]).
  - SUB: computed as x+~y+1. carry = 1 iff x>=y unsigned. overflow = (x[msb]!=y[msb]) && (res[msb]!=x[msb]).
  - All other ops: carry=0, overflow=0.
  - zero and negative are derived from the final result for every op.
  - err=1 only for opcodes 12-15, which also give result 0.
- Output hold: result and flags are registered when DONE is entered and stay stable for as long as DONE holds.
- Leaving DONE: out_valid && out_ready moves to IDLE at that edge. The next op can be accepted no earlier than the following cycle, so peak throughput is one op per 2 cycles.
- in_valid in BUSY/DONE: ignored; the upstream must hold its data until in_ready.
- out_ready in IDLE/BUSY: ignored.
- Shift amount is taken modulo WIDTH (only y[SHW-1:0] is used). SRA replicates x[msb].

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: OP_ADD..OP_MUL, OP_ILLEGAL_MIN=12;
  - state enum {S_IDLE, S_BUSY, S_DONE};
  - the flags struct {carry, overflow, zero, negative, err}.
- Sub-module alu_comb (parametrised by WIDTH): pure combinational evaluation of ops 0-7 plus flags. It is instantiated once in alu_seq.
- The shift/MUL iteration, counter and FSM live in alu_seq itself.

Test Plan:
- All tests use WIDTH=8.
- ADD x=0x7F, y=0x01 -> cycle C+1: result 0x80, overflow=1, carry=0, negative=1, zero=0. Then SUB x=0x80, y=0x01 -> result 0x7F, overflow=1, carry=1.
- SUB x=0x05, y=0x07 -> result 0xFE, carry=0, overflow=0, negative=1. Then EQ x=0x3C, y=0x3C -> result 0x01. Then SLT x=0xFF, y=0x01 -> result 0x01.
- Shifts:
  - SLL x=0x81, y=0x03 -> busy for 3 cycles, out_valid at C+4, result 0x08.
  - SRA x=0x90, y=0x02 -> result 0xE4.
  - SRL x=0x90, y=0x08 (amount 0) -> out_valid at C+1, result 0x90.
- MUL x=13, y=11 -> out_valid exactly at C+9, result 0x8F, zero=0. Then MUL x=0x10, y=0x10 -> result 0x00, zero=1.
- Backpressure: ADD accepted, out_ready held 0 for 5 cycles -> out_valid stays 1, result constant, in_ready=0, and a new in_valid is ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset and illegal opcode:
  - rst_n=0 for one edge in the 4th BUSY cycle of a MUL -> next cycle: IDLE, result 0, all flags 0, out_valid 0, no later out_valid.
  - op=13 -> result 0, err=1 at C+1.
